// File: rtl/data_mem_pkg.sv
// Shared MemOp encodings, access sizes and controller state type for the
// data-memory controller slice.
package data_mem_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Reserved encodings (011/110/111) fall through to word accesses.
    function automatic size_t memop_size(input logic [2:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU: memop_size = SZ_BYTE;
            MEMOP_LH, MEMOP_LHU: memop_size = SZ_HALF;
            default:             memop_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic memop_signed(input logic [2:0] op);
        memop_signed = ~op[2];
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response bundle of the data-memory controller.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_memop;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_memop, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_memop, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_align.sv
// Byte/half lane extraction for loads and read-modify-write merge for
// sub-word stores; purely combinational.
module load_store_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sgn;

    always_comb begin
        sgn    = memop_signed(memop);
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase

        load_data  = rdata;
        store_data = rdata;
        case (memop_size(memop))
            SZ_BYTE: begin
                load_data = sgn ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                case (lane)
                    2'd0:    store_data[7:0]   = wdata[7:0];
                    2'd1:    store_data[15:8]  = wdata[7:0];
                    2'd2:    store_data[23:16] = wdata[7:0];
                    default: store_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = sgn ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
                if (lane[1]) store_data[31:16] = wdata;
                else         store_data[15:0]  = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: CPU load/store requests onto a synchronous word RAM
// with read-modify-write for sub-word stores. Option: MISALIGN_TRAP_EN.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_ctrl_if.slave       bus,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);
    state_t            state, state_nx;
    logic              accept;
    logic              misaligned;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        memop_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    assign accept = bus.req_valid && (state == ST_IDLE);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (memop_size(bus.req_memop))
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    load_store_align u_align (
        .memop      (memop_q),
        .lane       (addr_q[1:0]),
        .rdata      (ram_rdata),
        .wdata      (merged_q[15:0]),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // merged_q carries the raw store data until WAIT overwrites it with the merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            memop_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    we_q     <= bus.req_we;
                    err_q    <= misaligned;
                    addr_q   <= bus.req_addr[ADDR_W+1:0];
                    memop_q  <= bus.req_memop;
                    merged_q <= bus.req_wdata;
                end
                ST_WAIT: begin
                    if (we_q) merged_q <= store_data;
                    else      rdata_q  <= load_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (misaligned)
                    state_nx = ST_RESP;
                else if (bus.req_we && memop_size(bus.req_memop) == SZ_WORD)
                    state_nx = ST_WRITE;
                else
                    state_nx = ST_READ;
            end
            ST_READ:  state_nx = ST_WAIT;
            ST_WAIT:  state_nx = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = (state == ST_READ) || (state == ST_WRITE);
        ram_we    = (state == ST_WRITE);
        ram_addr  = ram_en ? addr_q[ADDR_W+1:2] : '0;
        ram_wdata = ram_we ? merged_q : '0;
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    // Last load result stays visible; store and trap completions present zero.
    assign bus.resp_rdata = (state == ST_RESP && (we_q || err_q)) ? '0 : rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.resp_err   = (state == ST_RESP) && err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a behavioural word RAM.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int unsigned ADDR_W = 15;

    logic              clk;
    logic              rst_n;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          resp_cnt = 0;
    int          cyc = 0;
    logic [ADDR_W-1:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    int          acc_log[$];
    int          resp_log[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= ram_addr;
            last_wd <= ram_wdata;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            rd_cnt    <= rd_cnt + 1;
        end
        if (bus.resp_valid) begin
            resp_cnt <= resp_cnt + 1;
            resp_log.push_back(cyc);
        end
        if (bus.req_valid && bus.req_ready) acc_log.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] op,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int nwr, output int nrd);
        int w0, r0;
        @(negedge clk);
        w0 = wr_cnt;
        r0 = rd_cnt;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_memop = op;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.req_valid = 1'b0;
        end while (!bus.resp_valid && lat < 12);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        nwr   = wr_cnt - w0;
        nrd   = rd_cnt - r0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_memop = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: ready=%b valid=%b err=%b required 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err);
        end
        n_vec++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 ||
            bus.resp_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_ram: en=%b we=%b addr=%h wdata=%h rdata=%h required all zero",
                     ram_en, ram_we, ram_addr, ram_wdata, bus.resp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int lat, nwr, nrd;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, 32'h40, MEMOP_LW, 32'h8899AABB, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 2 || nwr != 1 || nrd != 0 || last_wa !== 15'h10 || last_wd !== 32'h8899AABB) begin
            n_err++;
            $display("FAIL setup_sw: lat=%0d wr=%0d rd=%0d wa=%h wd=%h required 2 1 0 0010 8899aabb",
                     lat, nwr, nrd, last_wa, last_wd);
        end
        do_req(1'b0, 32'h41, MEMOP_LB, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 3 || rd !== 32'hFFFFFFAA || err !== 1'b0 || nrd != 1) begin
            n_err++;
            $display("FAIL lb_41: lat=%0d rdata=%h err=%b rd=%0d required 3 ffffffaa 0 1", lat, rd, err, nrd);
        end
        do_req(1'b0, 32'h41, MEMOP_LBU, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 3 || rd !== 32'h000000AA) begin
            n_err++;
            $display("FAIL lbu_41: lat=%0d rdata=%h required 3 000000aa", lat, rd);
        end
        do_req(1'b0, 32'h42, MEMOP_LH, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 3 || rd !== 32'hFFFF8899) begin
            n_err++;
            $display("FAIL lh_42: lat=%0d rdata=%h required 3 ffff8899", lat, rd);
        end
        do_req(1'b0, 32'h42, MEMOP_LHU, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (rd !== 32'h00008899) begin
            n_err++;
            $display("FAIL lhu_42: rdata=%h required 00008899", rd);
        end
        do_req(1'b0, 32'h43, MEMOP_LB, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (rd !== 32'hFFFFFF88) begin
            n_err++;
            $display("FAIL lb_43: rdata=%h required ffffff88", rd);
        end
    endtask

    task automatic test_store_sub();
        int lat, nwr, nrd;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, 32'h42, MEMOP_LH, 32'h12345678, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 4 || nwr != 1 || nrd != 1 || last_wa !== 15'h10 || last_wd !== 32'h5678AABB || rd !== '0) begin
            n_err++;
            $display("FAIL sh_42: lat=%0d wr=%0d rd=%0d wa=%h wd=%h rdata=%h required 4 1 1 0010 5678aabb 0",
                     lat, nwr, nrd, last_wa, last_wd, rd);
        end
        do_req(1'b1, 32'h40, MEMOP_LB, 32'h000000EE, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 4 || nwr != 1 || last_wd !== 32'h5678AAEE) begin
            n_err++;
            $display("FAIL sb_40: lat=%0d wr=%0d wd=%h required 4 1 5678aaee", lat, nwr, last_wd);
        end
    endtask

    task automatic test_store_word();
        int lat, nwr, nrd;
        logic [31:0] rd;
        logic err;
        do_req(1'b1, 32'h44, MEMOP_LW, 32'hDEADBEEF, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 2 || nwr != 1 || nrd != 0 || last_wa !== 15'h11 || last_wd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL sw_44: lat=%0d wr=%0d rd=%0d wa=%h wd=%h required 2 1 0 0011 deadbeef",
                     lat, nwr, nrd, last_wa, last_wd);
        end
        do_req(1'b0, 32'h44, MEMOP_LW, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (lat != 3 || rd !== 32'hDEADBEEF || nwr != 0) begin
            n_err++;
            $display("FAIL lw_44: lat=%0d rdata=%h wr=%0d required 3 deadbeef 0", lat, rd, nwr);
        end
        do_req(1'b0, 32'h00020044, MEMOP_LW, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL lw_wrap: rdata=%h required deadbeef", rd);
        end
    endtask

    task automatic test_misalign();
        int lat, nwr, nrd;
        logic [31:0] rd;
        logic err;
        do_req(1'b0, 32'h46, MEMOP_LW, '0, lat, rd, err, nwr, nrd);
        n_vec++;
`ifdef MISALIGN_TRAP_EN
        if (lat != 1 || err !== 1'b1 || rd !== '0 || nrd != 0 || nwr != 0) begin
            n_err++;
            $display("FAIL lw_46_trap: lat=%0d err=%b rdata=%h rd=%0d wr=%0d required 1 1 0 0 0",
                     lat, err, rd, nrd, nwr);
        end
`else
        if (lat != 3 || err !== 1'b0 || rd !== 32'hDEADBEEF || nrd != 1) begin
            n_err++;
            $display("FAIL lw_46: lat=%0d err=%b rdata=%h rd=%0d required 3 0 deadbeef 1", lat, err, rd, nrd);
        end
        do_req(1'b0, 32'h43, MEMOP_LH, '0, lat, rd, err, nwr, nrd);
        n_vec++;
        if (rd !== 32'h00005678 || err !== 1'b0) begin
            n_err++;
            $display("FAIL lh_43: rdata=%h err=%b required 00005678 0", rd, err);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int w0, r0;
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h48;
        bus.req_memop = MEMOP_LB;
        bus.req_wdata = 32'h00000077;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        w0 = wr_cnt;
        r0 = resp_cnt;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ram_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_now: en=%b ready=%b valid=%b required 0 1 0",
                     ram_en, bus.req_ready, bus.resp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if (wr_cnt != w0 || resp_cnt != r0 || bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_after: writes=%0d resps=%0d ready=%b required 0 0 1",
                     wr_cnt - w0, resp_cnt - r0, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int ab, rb, n;
        @(negedge clk);
        ab = acc_log.size();
        rb = resp_log.size();
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h44;
        bus.req_memop = MEMOP_LW;
        bus.req_valid = 1'b1;
        n = 0;
        while (acc_log.size() < ab + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (resp_log.size() < rb + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (acc_log.size() < ab + 2 || resp_log.size() < rb + 2) begin
            n_err++;
            $display("FAIL b2b_timeout: accepts=%0d resps=%0d required 2 2",
                     acc_log.size() - ab, resp_log.size() - rb);
        end else begin
            if (acc_log[ab+1] != resp_log[rb] + 1 || acc_log[ab+1] - acc_log[ab] != 4) begin
                n_err++;
                $display("FAIL b2b_accept: second accept cycle=%0d first resp cycle=%0d gap=%0d required resp+1, gap 4",
                         acc_log[ab+1], resp_log[rb], acc_log[ab+1] - acc_log[ab]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_sub();
        test_store_word();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
